// File: rtl/rc4_stream_gen_if.sv
// Key-load, control and keystream handshake bundle for rc4_stream_gen.
// master = key loader / keystream consumer, slave = the generator.
interface rc4_stream_gen_if;
    logic       key_wr_en;
    logic [7:0] key_wr_addr;
    logic [7:0] key_wr_data;
    logic [8:0] key_len;
    logic       init_start;
    logic       stop;
    logic       busy;
    logic       key_err;
    logic       ks_valid;
    logic       ks_ready;
    logic [7:0] ks_data;

    modport master (
        output key_wr_en, key_wr_addr, key_wr_data, key_len, init_start, stop, ks_ready,
        input  busy, key_err, ks_valid, ks_data
    );

    modport slave (
        input  key_wr_en, key_wr_addr, key_wr_data, key_len, init_start, stop, ks_ready,
        output busy, key_err, ks_valid, ks_data
    );
endinterface

// File: rtl/rc4_stream_gen.sv
// RC4 keystream generator: 256-cycle S init, 256-cycle KSA, then one byte per 3 cycles.
// Optional RC4_DROP_EN macro compiles in discarding of the first DROP_N keystream bytes.
module rc4_stream_gen #(
    parameter int KEY_LEN_MAX = 16,
    parameter int DROP_N      = 768
) (
    input logic              clk,
    input logic              rst_n,
    rc4_stream_gen_if.slave  bus
);

    localparam int KW = (KEY_LEN_MAX > 1) ? $clog2(KEY_LEN_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        KSA,
`ifdef RC4_DROP_EN
        DROP,
`endif
        GEN1,
        GEN2,
        VALID
    } state_t;

    state_t     state, state_nxt;

    logic [7:0] s       [256];
    logic [7:0] key_mem [1 << KW];

    logic [7:0]    i, j;
    logic [KW-1:0] kidx;
    logic [8:0]    len;
    logic [7:0]    ks_data_q;
    logic          key_err_q;

    logic [7:0] gi, gj, kj, oidx, sa, sb;
    logic       swap_en, start_ok, can_start, key_wr_ok;

`ifdef RC4_DROP_EN
    localparam int DW = (DROP_N > 1) ? $clog2(DROP_N) : 1;
    logic [DW-1:0] drop_cnt;
    logic          drop_ph;
    logic          drop_last;
    assign drop_last = (drop_cnt == DW'(DROP_N - 1));
`endif

    always_comb begin
        gi        = i + 8'd1;
        gj        = j + s[gi];
        kj        = j + s[i] + key_mem[kidx];
        oidx      = s[i] + s[j];
        start_ok  = (bus.key_len != 9'd0) && (bus.key_len <= 9'(KEY_LEN_MAX));
        can_start = (state == IDLE) || (state == GEN1) || (state == GEN2) || (state == VALID);
        key_wr_ok = bus.key_wr_en && ({1'b0, bus.key_wr_addr} < 9'(KEY_LEN_MAX)) &&
                    (state != INIT) && (state != KSA);
        swap_en   = 1'b0;
        sa        = gi;
        sb        = gj;
        state_nxt = state;
        case (state)
            IDLE: ;
            INIT: if (i == 8'hFF) state_nxt = KSA;
            KSA: begin
                swap_en = 1'b1;
                sa      = i;
                sb      = kj;
                if (i == 8'hFF)
`ifdef RC4_DROP_EN
                    state_nxt = (DROP_N > 0) ? DROP : GEN1;
`else
                    state_nxt = GEN1;
`endif
            end
`ifdef RC4_DROP_EN
            // Even phase does the GEN1 swap, odd phase stands in for GEN2 and counts.
            DROP: begin
                swap_en = !drop_ph;
                if (drop_ph && drop_last) state_nxt = GEN1;
            end
`endif
            GEN1: begin
                swap_en   = 1'b1;
                state_nxt = GEN2;
            end
            GEN2:  state_nxt = VALID;
            VALID: if (bus.ks_ready) state_nxt = GEN1;
            default: state_nxt = IDLE;
        endcase
        if (bus.init_start && can_start) state_nxt = start_ok ? INIT : IDLE;
        if (bus.stop) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i         <= 8'd0;
            j         <= 8'd0;
            kidx      <= '0;
            len       <= 9'd0;
            ks_data_q <= 8'd0;
            key_err_q <= 1'b0;
`ifdef RC4_DROP_EN
            drop_cnt  <= '0;
            drop_ph   <= 1'b0;
`endif
        end else begin
            case (state)
                INIT: i <= i + 8'd1;
                KSA: begin
                    i    <= i + 8'd1;
                    j    <= (i == 8'hFF) ? 8'd0 : kj;
                    kidx <= (9'(kidx) == len - 9'd1) ? '0 : kidx + KW'(1);
                end
`ifdef RC4_DROP_EN
                DROP: begin
                    if (!drop_ph) begin
                        i       <= gi;
                        j       <= gj;
                        drop_ph <= 1'b1;
                    end else begin
                        drop_ph  <= 1'b0;
                        drop_cnt <= drop_cnt + DW'(1);
                    end
                end
`endif
                GEN1: begin
                    i <= gi;
                    j <= gj;
                end
                GEN2: ks_data_q <= s[oidx];
                default: ;
            endcase
            // A start request always rewrites the error flag; a rejected one leaves the counters alone.
            if (!bus.stop && bus.init_start && can_start) begin
                key_err_q <= !start_ok;
                if (start_ok) begin
                    i    <= 8'd0;
                    j    <= 8'd0;
                    kidx <= '0;
                    len  <= bus.key_len;
`ifdef RC4_DROP_EN
                    drop_cnt <= '0;
                    drop_ph  <= 1'b0;
`endif
                end
            end
        end
    end

    // S-box and key store carry no reset; INIT rebuilds S before anything reads it.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            s[i] <= i;
        end else if (swap_en) begin
            s[sa] <= s[sb];
            s[sb] <= s[sa];
        end
        if (key_wr_ok) key_mem[bus.key_wr_addr[KW-1:0]] <= bus.key_wr_data;
    end

    assign bus.busy     = (state == INIT) || (state == KSA)
`ifdef RC4_DROP_EN
                          || (state == DROP)
`endif
                          ;
    assign bus.ks_valid = (state == VALID);
    assign bus.ks_data  = ks_data_q;
    assign bus.key_err  = key_err_q;

endmodule

// File: tb/tb_rc4_stream_gen.sv
// Randomized bench for rc4_stream_gen against a plain-arithmetic RC4 model plus known vectors.
module tb_rc4_stream_gen;
    localparam int KMAX = 16;
`ifdef RC4_DROP_EN
    localparam int DRP = 1;
`else
    localparam int DRP = 0;
`endif

    typedef logic [7:0] bq_t [$];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   nvec  = 0;
    int   nerr  = 0;
    logic [7:0] shadow [KMAX];

    rc4_stream_gen_if bus ();

    rc4_stream_gen #(.KEY_LEN_MAX(KMAX), .DROP_N(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put_byte(input logic [7:0] a, input logic [7:0] d, input bit accept);
        bus.key_wr_en   = 1'b1;
        bus.key_wr_addr = a;
        bus.key_wr_data = d;
        if (accept && a < KMAX) shadow[a] = d;
        tick;
        bus.key_wr_en = 1'b0;
    endtask

    task automatic put_key(input bq_t kb);
        for (int k = 0; k < kb.size(); k++) put_byte(8'(k), kb[k], 1'b1);
    endtask

    task automatic start(input int len);
        bus.key_len    = 9'(len);
        bus.init_start = 1'b1;
        tick;
        bus.init_start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.ks_valid && n < 3000) begin
            tick;
            n++;
        end
        chk("valid_seen", 32'(bus.ks_valid), 32'd1);
    endtask

    task automatic collect(input int n, input bit rnd, output bq_t q);
        int w;
        q = {};
        for (int k = 0; k < n; k++) begin
            w = 0;
            forever begin
                bus.ks_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (bus.ks_valid && bus.ks_ready) begin
                    q.push_back(bus.ks_data);
                    tick;
                    break;
                end
                tick;
                w++;
                if (w > 3000) begin
                    chk("collect_timeout", 32'(bus.ks_valid), 32'd1);
                    bus.ks_ready = 1'b0;
                    return;
                end
            end
        end
        bus.ks_ready = 1'b0;
    endtask

    // Textbook RC4 over the shadow key, dropping DRP leading bytes.
    function automatic bq_t rc4_ref(input int len, input int n);
        int  s [256];
        int  i, j, t;
        bq_t q;
        q = {};
        for (int k = 0; k < 256; k++) s[k] = k;
        j = 0;
        for (int k = 0; k < 256; k++) begin
            j = (j + s[k] + int'(shadow[k % len])) % 256;
            t = s[k]; s[k] = s[j]; s[j] = t;
        end
        i = 0;
        j = 0;
        for (int k = 0; k < n + DRP; k++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            if (k >= DRP) q.push_back(8'(s[(s[i] + s[j]) % 256]));
        end
        return q;
    endfunction

    task automatic chk_kv(input string tag, input bq_t got, input bq_t exp);
        for (int k = 0; k < got.size(); k++)
            if (k + DRP < exp.size())
                chk($sformatf("%s[%0d]", tag, k), 32'(got[k]), 32'(exp[k + DRP]));
    endtask

    task automatic chk_q(input string tag, input bq_t got, input bq_t exp, input int off);
        chk({tag, "_count"}, 32'(got.size()), 32'(exp.size() - off));
        for (int k = 0; k < got.size() && k + off < exp.size(); k++)
            chk($sformatf("%s[%0d]", tag, k), 32'(got[k]), 32'(exp[k + off]));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bq_t k_key, k_wiki, k_sec, e_key, e_wiki, e_sec, q, exp, kb;
        int  n, len;
        k_key  = '{8'h4B, 8'h65, 8'h79};
        k_wiki = '{8'h57, 8'h69, 8'h6B, 8'h69};
        k_sec  = '{8'h53, 8'h65, 8'h63, 8'h72, 8'h65, 8'h74};
        e_key  = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
        e_wiki = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};
        e_sec  = '{8'h04, 8'hD4, 8'h6B, 8'h05, 8'h3C, 8'hA8, 8'h7B, 8'h59};

        bus.key_wr_en = 0; bus.key_wr_addr = 0; bus.key_wr_data = 0;
        bus.key_len = 0; bus.init_start = 0; bus.stop = 0; bus.ks_ready = 0;
        tick; tick;
        chk("rst_busy",     32'(bus.busy),     0);
        chk("rst_key_err",  32'(bus.key_err),  0);
        chk("rst_ks_valid", 32'(bus.ks_valid), 0);
        chk("rst_ks_data",  32'(bus.ks_data),  0);
        rst_n = 1'b1;
        tick;

        // "Key" known vector with first-byte latency
        put_key(k_key);
        start(3);
        chk("key_busy", 32'(bus.busy), 1);
        wait_valid(n);
        chk("key_latency", 32'(n), 32'(514 + 2 * DRP));
        collect(10, 1'b0, q);
        chk_kv("key", q, e_key);

        // "Wiki", then re-key to "Secret" while the stream is live
        put_key(k_wiki);
        start(4);
        wait_valid(n);
        collect(6, 1'b0, q);
        chk_kv("wiki", q, e_wiki);
        put_key(k_sec);
        start(6);
        wait_valid(n);
        collect(8, 1'b0, q);
        chk_kv("secret", q, e_sec);

        // Backpressure: held byte stays put, and nothing is skipped afterwards
        exp = rc4_ref(6, 14);
        wait_valid(n);
        for (int c = 0; c < 10; c++) begin
            chk("stall_valid", 32'(bus.ks_valid), 1);
            chk("stall_data",  32'(bus.ks_data),  32'(exp[8]));
            tick;
        end
        collect(6, 1'b0, q);
        chk_q("post_stall", q, exp, 8);

        // Stop, illegal lengths, stop beating start, then a legal start
        bus.stop = 1'b1;
        tick;
        bus.stop = 1'b0;
        chk("stop_valid", 32'(bus.ks_valid), 0);
        chk("stop_busy",  32'(bus.busy),     0);
        start(0);
        chk("len0_err",  32'(bus.key_err), 1);
        chk("len0_busy", 32'(bus.busy),    0);
        start(17);
        chk("len17_err",  32'(bus.key_err), 1);
        chk("len17_busy", 32'(bus.busy),    0);
        bus.stop = 1'b1;
        start(6);
        bus.stop = 1'b0;
        chk("stopwin_busy", 32'(bus.busy),    0);
        chk("stopwin_err",  32'(bus.key_err), 1);
        start(6);
        chk("legal_err",  32'(bus.key_err), 0);
        chk("legal_busy", 32'(bus.busy),    1);
        wait_valid(n);
        collect(3, 1'b0, q);
        chk_q("legal", q, rc4_ref(6, 3), 0);

        // Asynchronous reset in the middle of KSA
        put_key(k_key);
        start(3);
        repeat (356) tick;
        chk("ksa_busy", 32'(bus.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",     32'(bus.busy),     0);
        chk("arst_key_err",  32'(bus.key_err),  0);
        chk("arst_ks_valid", 32'(bus.ks_valid), 0);
        chk("arst_ks_data",  32'(bus.ks_data),  0);
        tick;
        rst_n = 1'b1;
        tick;
        put_key(k_key);
        start(3);
        wait_valid(n);
        chk("rerun_latency", 32'(n), 32'(514 + 2 * DRP));
        collect(2, 1'b0, q);
        chk_kv("rerun", q, e_key);

        // Random keys/lengths, ignored out-of-range and mid-INIT writes, random ready
        for (int r = 0; r < 6; r++) begin
            len = (r == 0) ? KMAX : (r == 1) ? 1 : int'($urandom_range(1, KMAX));
            kb = {};
            for (int k = 0; k < KMAX; k++) kb.push_back(8'($urandom));
            put_key(kb);
            put_byte(8'($urandom_range(KMAX, 255)), 8'($urandom), 1'b1);
            put_byte(8'($urandom_range(KMAX, 255)), 8'($urandom), 1'b1);
            start(len);
            for (int k = 0; k < 3; k++) put_byte(8'(k), 8'($urandom), 1'b0);
            wait_valid(n);
            collect(12, 1'b1, q);
            chk_q($sformatf("rnd%0d_len%0d", r, len), q, rc4_ref(len, 12), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/rc4_stream_gen.md
RC4_STREAM_GEN -- requirements
Module: rc4_stream_gen

Interface
REQ-001 The block SHALL have parameter KEY_LEN_MAX, default 16, meaning maximum key length in bytes (legal 1..256).
REQ-002 The block SHALL have parameter DROP_N, default 768, meaning the number of initial keystream bytes discarded when drop is compiled in.
REQ-003 The block SHALL have port clk  input  1  the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port key_wr_en  input  1  key byte write strobe.
REQ-006 The block SHALL have port key_wr_addr  input  8  key byte index, with writes where the index is KEY_LEN_MAX or greater ignored.
REQ-007 The block SHALL have port key_wr_data  input  8  key byte value.
REQ-008 The block SHALL have port key_len  input  9  active key length, sampled with init_start.
REQ-009 The block SHALL have port init_start  input  1  single-cycle request to (re)key.
REQ-010 The block SHALL have port stop  input  1  abort to IDLE.
REQ-011 The block SHALL have port busy  output  1  high in INIT, KSA and DROP.
REQ-012 The block SHALL have port key_err  output  1  sticky flag for an illegal key_len.
REQ-013 The block SHALL have port ks_valid  output  1  keystream byte available.
REQ-014 The block SHALL have port ks_ready  input  1  consumer accepts the byte.
REQ-015 The block SHALL have port ks_data  output  8  keystream byte.

Function
REQ-016 The block SHALL hold S-box S[0..255] (8b), key store[KEY_LEN_MAX], i and j (8b, modulo-256 arithmetic), a 9-bit length register, and FSM states IDLE, INIT, KSA, DROP, GEN1, GEN2, VALID.
REQ-017 In IDLE, init_start SHALL be accepted as follows: key_len of 1..KEY_LEN_MAX -> INIT with key_err cleared; key_len of 0 or greater than KEY_LEN_MAX -> key_err set and the FSM stays IDLE.
REQ-018 INIT SHALL take 256 cycles: S[n]=n for n=0..255, then i=0, j=0 -> KSA.
REQ-019 KSA SHALL take 256 cycles, one iteration per cycle: j'=j+S[i]+key[i mod len]; swap S[i],S[j']; i++; after i=255 -> DROP (drop enabled, DROP_N>0) else GEN1, with i=0 and j=0.
REQ-020 GEN1 SHALL perform i'=i+1; j'=j+S[i']; swap S[i'],S[j'] -> GEN2.
REQ-021 GEN2 SHALL register ks_data=S[(S[i]+S[j]) mod 256] (post-swap) -> VALID with ks_valid=1.
REQ-022 DROP SHALL run GEN1/GEN2 DROP_N times without asserting ks_valid, then -> GEN1.
REQ-023 In VALID, ks_data SHALL stay stable while ks_ready=0, and ks_valid&&ks_ready -> GEN1 with ks_valid=0 (throughput 1 byte per 3 cycles).
REQ-024 With DROP_N=0 or drop compiled out, ks_valid SHALL first rise 514 cycles after the edge sampling init_start.
REQ-025 init_start in VALID/GEN1/GEN2 SHALL restart at INIT (re-key), and init_start in INIT/KSA/DROP SHALL be ignored.
REQ-026 stop in any state SHALL -> IDLE next edge with ks_valid=0 and busy=0, and stop SHALL win over a simultaneous init_start.
REQ-027 Key writes SHALL be ignored in INIT and KSA and accepted in all other states, with a write in the same cycle as init_start taking effect before INIT.
REQ-028 The i and j counters SHALL wrap 255 -> 0 without flag.

Reset
REQ-029 rst_n low SHALL asynchronously force state IDLE, i=0, j=0, busy=0, key_err=0, ks_valid=0, ks_data=0x00, and drop counter 0.
REQ-030 S-box and key store SHALL be undefined after reset, with no output depending on them until INIT completes.
REQ-031 Reset asserted mid-INIT/KSA/DROP/VALID SHALL abandon the operation, and the first init_start after release SHALL behave as from power-up.

Configuration
REQ-032 Macro RC4_DROP_EN defined SHALL compile in the DROP state and drop counter, discarding DROP_N bytes per REQ-022.
REQ-033 RC4_DROP_EN undefined SHALL remove the DROP state and counter, make DROP_N ignored, and make KSA go directly to GEN1.

Verification
REQ-034 The bench SHALL check: key 4B 65 79 ("Key"), len=3, ks_ready=1, drop off -> ks_data EB 9F 77 81 B7 34 CA 72 A7 19, first ks_valid 514 cycles after start.
REQ-035 The bench SHALL check: key "Wiki" (57 69 6B 69), len=4 -> 60 44 DB 6D 41 B7; then re-key "Secret" mid-stream -> 04 D4 6B 05 3C A8 7B 59.
REQ-036 The bench SHALL check: RC4_DROP_EN, DROP_N=1, key "Key" -> first delivered byte 9F, then 77.
REQ-037 The bench SHALL check: ks_ready held 0 for 10 cycles in VALID -> ks_data constant and ks_valid=1 throughout, with no byte skipped after release.
REQ-038 The bench SHALL check: init_start with key_len=0, then with key_len=17 -> key_err=1, busy=0; then a legal start -> key_err=0.
REQ-039 The bench SHALL check: rst_n pulsed low at KSA cycle 100 -> all outputs at reset values immediately, and a subsequent "Key" run reproduces EB 9F.
